// File: rtl/lcd_responder_if.sv
// LCD control strobes from the host plus the decoded byte stream and status
// presented by the device-side responder.
interface lcd_responder_if;
    logic       LCD_RW;
    logic       LCD_E;
    logic       LCD_RS;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_rs;
    logic       busy;
    logic [6:0] addr;
    logic       mode4;
    logic       overrun;

    modport master (
        output LCD_RW, LCD_E, LCD_RS,
        input  byte_valid, byte_data, byte_rs, busy, addr, mode4, overrun
    );

    modport slave (
        input  LCD_RW, LCD_E, LCD_RS,
        output byte_valid, byte_data, byte_rs, busy, addr, mode4, overrun
    );
endinterface

// File: rtl/lcd_responder.sv
// Device-side HD44780-style 4-bit bus responder: decodes nibble writes into
// bytes, tracks the DDRAM address, models busy time and answers status reads.
module lcd_responder #(
    parameter int FREQ             = 50000000,
    parameter int BUSY_CYCLES      = 2000,
    parameter int LONG_BUSY_CYCLES = 76500
) (
    input  logic              CLK,
    input  logic              RST,
    inout  wire  [3:0]        LCD_D,
    lcd_responder_if.slave    bus
);
    // FREQ is informational only; it takes part here just to keep it referenced.
    localparam int CW = (FREQ > 0) ? $clog2(LONG_BUSY_CYCLES + 1) : 1;

    logic          e_sync1_r, e_sync2_r, e_dly_r;
    logic          rs_sync1_r, rs_sync2_r;
    logic          rw_sync1_r, rw_sync2_r;
    logic [3:0]    d_sync1_r, d_sync2_r;
    logic          byte_valid_r, byte_rs_r, busy_r, mode4_r, overrun_r;
    logic [7:0]    byte_data_r;
    logic [6:0]    addr_r;
    logic          phase_r, last_wr_r;
    logic [3:0]    hi_nib_r, rd_nibble_r;
    logic [CW-1:0] cnt_r;

    logic          e_rise_s, e_fall_s;
    logic          done_s, done_rs_s, long_s, eff_phase_s;
    logic [7:0]    done_byte_s;
    logic          phase_n_s, mode4_n_s, last_wr_n_s;
    logic [3:0]    hi_nib_n_s, rd_nibble_n_s;
    logic [6:0]    addr_n_s;
    logic [CW-1:0] cnt_n_s;

    // The enable follows the raw pin so the bus turns around with no delay.
    assign LCD_D = bus.LCD_RW ? rd_nibble_r : 4'bzzzz;

    assign e_rise_s = e_sync2_r & ~e_dly_r;
    assign e_fall_s = ~e_sync2_r & e_dly_r;

    // Bus decode: nibble assembly, interface mode, read phase and status capture.
    always_comb begin
        done_s        = 1'b0;
        done_rs_s     = rs_sync2_r;
        done_byte_s   = 8'h00;
        eff_phase_s   = 1'b0;
        phase_n_s     = phase_r;
        mode4_n_s     = mode4_r;
        last_wr_n_s   = last_wr_r;
        hi_nib_n_s    = hi_nib_r;
        rd_nibble_n_s = rd_nibble_r;
        if (e_fall_s && !rw_sync2_r) begin
            last_wr_n_s = 1'b1;
            if (!mode4_r) begin
                done_s      = 1'b1;
                done_byte_s = {d_sync2_r, 4'h0};
                if (!rs_sync2_r && (d_sync2_r == 4'h2)) begin
                    mode4_n_s = 1'b1;
                    phase_n_s = 1'b0;
                end else begin
                    mode4_n_s = mode4_r;
                end
            end else if (!phase_r) begin
                hi_nib_n_s = d_sync2_r;
                phase_n_s  = 1'b1;
            end else begin
                done_s      = 1'b1;
                done_byte_s = {hi_nib_r, d_sync2_r};
                phase_n_s   = 1'b0;
            end
        end else if (e_fall_s && rw_sync2_r) begin
            last_wr_n_s = 1'b0;
            if (mode4_r) begin
                phase_n_s = ~phase_r;
            end else begin
                phase_n_s = phase_r;
            end
        end else if (e_rise_s && rw_sync2_r) begin
            // A read right after a write drops any half-written byte.
            eff_phase_s = phase_r & ~last_wr_r;
            phase_n_s   = eff_phase_s;
            if (rs_sync2_r) begin
                rd_nibble_n_s = 4'h0;
            end else if (mode4_r && eff_phase_s) begin
                rd_nibble_n_s = addr_r[3:0];
            end else begin
                rd_nibble_n_s = {busy_r, addr_r[6:4]};
            end
        end else begin
            phase_n_s = phase_r;
        end
    end

    // Address counter and busy timer reaction to a completed byte.
    always_comb begin
        long_s   = !done_rs_s && ((done_byte_s == 8'h01) || (done_byte_s == 8'h02) ||
                                  (done_byte_s == 8'h03));
        addr_n_s = addr_r;
        cnt_n_s  = cnt_r;
        if (done_s) begin
            if (done_rs_s) begin
                addr_n_s = addr_r + 7'd1;
            end else if (long_s) begin
                addr_n_s = 7'h00;
            end else if (done_byte_s[7]) begin
                addr_n_s = done_byte_s[6:0];
            end else begin
                addr_n_s = addr_r;
            end
            cnt_n_s = long_s ? CW'(LONG_BUSY_CYCLES) : CW'(BUSY_CYCLES);
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_n_s = cnt_r - CW'(1'b1);
        end else begin
            cnt_n_s = {CW{1'b0}};
        end
    end

    // Synchronizers, edge history and all architectural state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            e_sync1_r    <= 1'b0;
            e_sync2_r    <= 1'b0;
            e_dly_r      <= 1'b0;
            rs_sync1_r   <= 1'b0;
            rs_sync2_r   <= 1'b0;
            rw_sync1_r   <= 1'b0;
            rw_sync2_r   <= 1'b0;
            d_sync1_r    <= 4'h0;
            d_sync2_r    <= 4'h0;
            byte_valid_r <= 1'b0;
            byte_data_r  <= 8'h00;
            byte_rs_r    <= 1'b0;
            busy_r       <= 1'b0;
            addr_r       <= 7'h00;
            mode4_r      <= 1'b0;
            overrun_r    <= 1'b0;
            phase_r      <= 1'b0;
            last_wr_r    <= 1'b0;
            hi_nib_r     <= 4'h0;
            rd_nibble_r  <= 4'h0;
            cnt_r        <= {CW{1'b0}};
        end else begin
            e_sync1_r    <= bus.LCD_E;
            e_sync2_r    <= e_sync1_r;
            e_dly_r      <= e_sync2_r;
            rs_sync1_r   <= bus.LCD_RS;
            rs_sync2_r   <= rs_sync1_r;
            rw_sync1_r   <= bus.LCD_RW;
            rw_sync2_r   <= rw_sync1_r;
            d_sync1_r    <= LCD_D;
            d_sync2_r    <= d_sync1_r;
            byte_valid_r <= done_s;
            byte_data_r  <= done_s ? done_byte_s : byte_data_r;
            byte_rs_r    <= done_s ? done_rs_s : byte_rs_r;
            overrun_r    <= done_s & busy_r;
            busy_r       <= (cnt_n_s != {CW{1'b0}});
            addr_r       <= addr_n_s;
            mode4_r      <= mode4_n_s;
            phase_r      <= phase_n_s;
            last_wr_r    <= last_wr_n_s;
            hi_nib_r     <= hi_nib_n_s;
            rd_nibble_r  <= rd_nibble_n_s;
            cnt_r        <= cnt_n_s;
        end
    end

    assign bus.byte_valid = byte_valid_r;
    assign bus.byte_data  = byte_data_r;
    assign bus.byte_rs    = byte_rs_r;
    assign bus.busy       = busy_r;
    assign bus.addr       = addr_r;
    assign bus.mode4      = mode4_r;
    assign bus.overrun    = overrun_r;
endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: table of nibble writes plus hand-written
// sequences for busy timing, status reads, overrun and mid-byte reset.
module tb_lcd_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic       host_oe;
    logic [3:0] host_d;
    wire  [3:0] lcd_d;

    int nvec = 0;
    int nbad = 0;
    int cyc = 0;
    int nvalid = 0;
    int nover = 0;
    int valid_cyc = 0;
    int fall_cyc = 0;
    int drop_cyc = 0;
    logic busy_prev = 1'b0;

    lcd_responder_if bus ();

    assign lcd_d = host_oe ? host_d : 4'bzzzz;
    pullup (lcd_d[0]);
    pullup (lcd_d[1]);
    pullup (lcd_d[2]);
    pullup (lcd_d[3]);

    lcd_responder #(.FREQ(50000000), .BUSY_CYCLES(2000), .LONG_BUSY_CYCLES(76500)) dut (
        .CLK  (clk),
        .RST  (rst),
        .LCD_D(lcd_d),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.byte_valid) begin
            nvalid    <= nvalid + 1;
            valid_cyc <= cyc;
        end
        if (bus.overrun) nover <= nover + 1;
        if (busy_prev && !bus.busy) fall_cyc <= cyc;
        busy_prev <= bus.busy;
    end

    typedef struct {
        logic       rs;
        logic [3:0] nib;
        logic       vld;
        logic [7:0] data;
        logic       brs;
        logic       m4;
        logic [6:0] addr;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_nib(input logic rs, input logic [3:0] n);
        bus.LCD_RW = 1'b0;
        bus.LCD_RS = rs;
        host_d     = n;
        host_oe    = 1'b1;
        tick(4);
        bus.LCD_E = 1'b1;
        tick(5);
        bus.LCD_E = 1'b0;
        drop_cyc  = cyc;
        tick(6);
    endtask

    task automatic rd_nib(input logic rs, output logic [3:0] v);
        host_oe    = 1'b0;
        bus.LCD_RS = rs;
        bus.LCD_RW = 1'b1;
        tick(4);
        bus.LCD_E = 1'b1;
        tick(5);
        v = lcd_d;
        bus.LCD_E = 1'b0;
        tick(4);
        bus.LCD_RW = 1'b0;
        #1;
        chk("bus_release", {28'd0, lcd_d}, 32'hF);
        tick(2);
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (bus.busy && k < limit) begin
            tick(1);
            k++;
        end
        chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
        tick(1);
    endtask

    initial begin
        logic [3:0] v;
        int n0, o0, vc;

        tbl[0]  = '{1'b0, 4'h3, 1'b1, 8'h30, 1'b0, 1'b0, 7'h00};
        tbl[1]  = '{1'b0, 4'h3, 1'b1, 8'h30, 1'b0, 1'b0, 7'h00};
        tbl[2]  = '{1'b0, 4'h3, 1'b1, 8'h30, 1'b0, 1'b0, 7'h00};
        tbl[3]  = '{1'b0, 4'h2, 1'b1, 8'h20, 1'b0, 1'b1, 7'h00};
        tbl[4]  = '{1'b0, 4'hC, 1'b0, 8'h00, 1'b0, 1'b1, 7'h00};
        tbl[5]  = '{1'b0, 4'h0, 1'b1, 8'hC0, 1'b0, 1'b1, 7'h40};
        tbl[6]  = '{1'b1, 4'h4, 1'b0, 8'h00, 1'b0, 1'b1, 7'h40};
        tbl[7]  = '{1'b1, 4'h1, 1'b1, 8'h41, 1'b1, 1'b1, 7'h41};
        tbl[8]  = '{1'b0, 4'hF, 1'b0, 8'h00, 1'b0, 1'b1, 7'h41};
        tbl[9]  = '{1'b0, 4'hF, 1'b1, 8'hFF, 1'b0, 1'b1, 7'h7F};
        tbl[10] = '{1'b1, 4'h4, 1'b0, 8'h00, 1'b0, 1'b1, 7'h7F};
        tbl[11] = '{1'b1, 4'h1, 1'b1, 8'h41, 1'b1, 1'b1, 7'h00};

        bus.LCD_E  = 1'b0;
        bus.LCD_RW = 1'b0;
        bus.LCD_RS = 1'b0;
        host_oe    = 1'b0;
        host_d     = 4'h0;
        rst        = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);

        chk("rst_byte_valid", {31'd0, bus.byte_valid}, 32'd0);
        chk("rst_byte_data", {24'd0, bus.byte_data}, 32'h00);
        chk("rst_byte_rs", {31'd0, bus.byte_rs}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_addr", {25'd0, bus.addr}, 32'h00);
        chk("rst_mode4", {31'd0, bus.mode4}, 32'd0);
        chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
        chk("rst_bus_z", {28'd0, lcd_d}, 32'hF);

        for (int i = 0; i < 12; i++) begin
            n0 = nvalid;
            wr_nib(tbl[i].rs, tbl[i].nib);
            chk($sformatf("v%0d_pulses", i), nvalid - n0, {31'd0, tbl[i].vld});
            if (tbl[i].vld) begin
                chk($sformatf("v%0d_data", i), {24'd0, bus.byte_data}, {24'd0, tbl[i].data});
                chk($sformatf("v%0d_rs", i), {31'd0, bus.byte_rs}, {31'd0, tbl[i].brs});
            end
            chk($sformatf("v%0d_mode4", i), {31'd0, bus.mode4}, {31'd0, tbl[i].m4});
            chk($sformatf("v%0d_addr", i), {25'd0, bus.addr}, {25'd0, tbl[i].addr});
        end

        // Status read while busy, then again after expiry.
        rd_nib(1'b0, v);
        chk("busy_read_hi", {28'd0, v}, 32'h8);
        rd_nib(1'b0, v);
        chk("busy_read_lo", {28'd0, v}, 32'h0);
        wait_idle(5000);
        rd_nib(1'b0, v);
        chk("idle_read_hi", {28'd0, v}, 32'h0);
        rd_nib(1'b0, v);
        chk("idle_read_lo", {28'd0, v}, 32'h0);

        // Set-address 0xC5 from idle: latency and exact busy length.
        wr_nib(1'b0, 4'hC);
        wr_nib(1'b0, 4'h5);
        chk("latency", valid_cyc - drop_cyc, 32'd3);
        chk("addr_c5", {25'd0, bus.addr}, 32'h45);
        chk("busy_set", {31'd0, bus.busy}, 32'd1);
        vc = valid_cyc;
        wait_idle(5000);
        chk("busy_len", fall_cyc - vc, 32'd2000);

        rd_nib(1'b0, v);
        chk("read45_hi", {28'd0, v}, 32'h4);
        rd_nib(1'b0, v);
        chk("read45_lo", {28'd0, v}, 32'h5);

        // Half-written byte followed by a read is discarded.
        n0 = nvalid;
        wr_nib(1'b0, 4'h8);
        chk("pending_no_pulse", nvalid - n0, 32'd0);
        rd_nib(1'b0, v);
        chk("pending_read_hi", {28'd0, v}, 32'h4);
        rd_nib(1'b0, v);
        chk("pending_read_lo", {28'd0, v}, 32'h5);
        wr_nib(1'b0, 4'h9);
        wr_nib(1'b0, 4'h3);
        chk("realign_data", {24'd0, bus.byte_data}, 32'h93);
        chk("realign_addr", {25'd0, bus.addr}, 32'h13);
        wait_idle(5000);

        // Clear, then a data write 100 cycles into the long busy time.
        wr_nib(1'b0, 4'h0);
        wr_nib(1'b0, 4'h1);
        chk("clear_addr", {25'd0, bus.addr}, 32'h00);
        vc = valid_cyc;
        while (cyc < vc + 100) tick(1);
        chk("clear_busy_100", {31'd0, bus.busy}, 32'd1);
        o0 = nover;
        wr_nib(1'b1, 4'h5);
        wr_nib(1'b1, 4'hA);
        chk("overrun_pulse", nover - o0, 32'd1);
        chk("overrun_data", {24'd0, bus.byte_data}, 32'h5A);
        chk("overrun_addr", {25'd0, bus.addr}, 32'h01);
        vc = valid_cyc;
        wait_idle(5000);
        chk("reload_len", fall_cyc - vc, 32'd2000);

        // Reset with a high nibble pending.
        n0 = nvalid;
        wr_nib(1'b0, 4'h8);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("rst_mid_pulse", nvalid - n0, 32'd0);
        chk("rst_mid_mode4", {31'd0, bus.mode4}, 32'd0);
        chk("rst_mid_addr", {25'd0, bus.addr}, 32'h00);
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_data", {24'd0, bus.byte_data}, 32'h00);
        wr_nib(1'b0, 4'h3);
        chk("rst_8bit_pulse", nvalid - n0, 32'd1);
        chk("rst_8bit_data", {24'd0, bus.byte_data}, 32'h30);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
